// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard: counts outstanding writes per register and
// releases an instruction only when none of its sources has a write pending.
package reg_scoreboard_pkg;
  typedef logic [4:0] rv_reg_t;

  typedef struct packed {
    logic        enable;
    rv_reg_t     which_register;
    logic [31:0] value;
  } reg_write_control_t;
endpackage

module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  rv_reg_t            in_rs1,
  input  rv_reg_t            in_rs2,
  input  logic               in_rs1_used,
  input  logic               in_rs2_used,
  input  rv_reg_t            in_rd,
  input  logic               in_rd_write,
  output rv_reg_t            rf_rs1,
  output rv_reg_t            rf_rs2,
  output logic               out_valid,
  input  logic               out_ready,
  output rv_reg_t            out_rd,
  output logic               out_rd_write,
  input  reg_write_control_t wb_control,
  input  logic               kill_valid,
  input  rv_reg_t            kill_rd
);
  localparam int               INF_W    = 4;
  localparam logic [CNT_W-1:0] PEND_SAT = '1;
  localparam logic [INF_W-1:0] INF_MAX  = INF_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] pend [NUM_REGS];
  logic [INF_W-1:0] inflight;
  rv_reg_t          held_rs1;
  rv_reg_t          held_rs2;
  logic             hazard;
  logic             out_free;
  logic             acc;
  logic             inc;
  logic             wb;
  logic             kl;

  // Decrements are gated on a nonzero counter so stale writebacks or kills
  // arriving right after a reset cannot wrap the counters.
  always_comb begin
    hazard   = (in_rs1_used && pend[in_rs1] != '0)
            || (in_rs2_used && pend[in_rs2] != '0)
            || (in_rd_write && in_rd != '0
                && (pend[in_rd] == PEND_SAT || inflight == INF_MAX));
    out_free = !out_valid || out_ready;
    in_ready = !reset && out_free && !hazard;
    acc      = in_valid && in_ready;
    inc      = acc && in_rd_write && in_rd != '0;
    wb       = wb_control.enable && wb_control.which_register != '0
            && pend[wb_control.which_register] != '0;
    kl       = kill_valid && kill_rd != '0 && pend[kill_rd] != '0;
    rf_rs1   = acc ? in_rs1 : held_rs1;
    rf_rs2   = acc ? in_rs2 : held_rs2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend[r] <= '0;
      end
      inflight     <= '0;
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_rd_write <= 1'b0;
      held_rs1     <= '0;
      held_rs2     <= '0;
    end else begin
      pend[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        pend[r] <= pend[r]
                 + CNT_W'(inc && in_rd == rv_reg_t'(r))
                 - CNT_W'(wb && wb_control.which_register == rv_reg_t'(r))
                 - CNT_W'(kl && kill_rd == rv_reg_t'(r));
      end
      inflight <= inflight + INF_W'(inc) - INF_W'(wb) - INF_W'(kl);

      // Held addresses keep the register file re-reading the issued
      // operands for as long as downstream stalls.
      if (acc) begin
        out_valid    <= 1'b1;
        out_rd       <= in_rd;
        out_rd_write <= in_rd_write;
        held_rs1     <= in_rs1;
        held_rs2     <= in_rs2;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard with a registered, non-forwarding register file
// model behind it and a queue-based output monitor.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  rv_reg_t            in_rs1 = '0;
  rv_reg_t            in_rs2 = '0;
  logic               in_rs1_used = 1'b0;
  logic               in_rs2_used = 1'b0;
  rv_reg_t            in_rd = '0;
  logic               in_rd_write = 1'b0;
  rv_reg_t            rf_rs1;
  rv_reg_t            rf_rs2;
  logic               out_valid;
  logic               out_ready = 1'b1;
  rv_reg_t            out_rd;
  logic               out_rd_write;
  reg_write_control_t wb_control = '0;
  logic               kill_valid = 1'b0;
  rv_reg_t            kill_rd = '0;

  logic [31:0] rf_mem [32];
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  typedef struct {
    rv_reg_t     rd;
    logic        rd_write;
    logic        use1;
    logic        use2;
    logic [31:0] val1;
    logic [31:0] val2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tb_pend[32];
  bit   first_cycle;
  int   w;

  reg_scoreboard dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_rd_write(in_rd_write),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rd_write(out_rd_write),
    .wb_control(wb_control),
    .kill_valid(kill_valid), .kill_rd(kill_rd)
  );

  always #5 clock = ~clock;

  initial begin
    foreach (rf_mem[r]) rf_mem[r] = '0;
  end

  // Register file model: registered reads, same-edge writes not forwarded.
  always @(posedge clock) begin
    rs1_val <= rf_mem[rf_rs1];
    rs2_val <= rf_mem[rf_rs2];
    if (wb_control.enable && wb_control.which_register != '0)
      rf_mem[wb_control.which_register] <= wb_control.value;
  end

  // Stimulus legality: the bench never retires a write it did not issue.
  always @(posedge clock) begin
    if (reset) begin
      foreach (tb_pend[r]) tb_pend[r] = 0;
      first_cycle = 1'b1;
    end else begin
      if (in_valid && in_ready && in_rd_write && in_rd != '0) tb_pend[in_rd]++;
      if (wb_control.enable && wb_control.which_register != '0) begin
        assert (first_cycle || tb_pend[wb_control.which_register] > 0)
          else $error("[TB] writeback to register with no pending write");
        if (tb_pend[wb_control.which_register] > 0) tb_pend[wb_control.which_register]--;
      end
      if (kill_valid && kill_rd != '0) begin
        assert (first_cycle || tb_pend[kill_rd] > 0)
          else $error("[TB] kill of register with no pending write");
        if (tb_pend[kill_rd] > 0) tb_pend[kill_rd]--;
      end
      first_cycle = 1'b0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got rd %0d, expected no output", out_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("out_rd", 32'(out_rd), 32'(e.rd));
        check_output("out_rd_write", 32'(out_rd_write), 32'(e.rd_write));
        if (e.use1) check_output("rs1_val", rs1_val, e.val1);
        if (e.use2) check_output("rs2_val", rs2_val, e.val2);
      end
    end
  end

  task automatic push_exp(input rv_reg_t rd, input logic wr, input logic u1, input logic u2,
                          input logic [31:0] v1, input logic [31:0] v2);
    exp_t e;
    e.rd = rd; e.rd_write = wr; e.use1 = u1; e.use2 = u2; e.val1 = v1; e.val2 = v2;
    exp_q.push_back(e);
  endtask

  task automatic offer(input rv_reg_t rs1, input logic u1, input rv_reg_t rs2, input logic u2,
                       input rv_reg_t rd, input logic wr);
    in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2;
    in_rd = rd; in_rd_write = wr; in_valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input rv_reg_t rs1, input logic u1, input rv_reg_t rs2, input logic u2,
                       input rv_reg_t rd, input logic wr, input logic [31:0] e1,
                       input logic [31:0] e2, output int waited);
    offer(rs1, u1, rs2, u2, rd, wr);
    waited = 0;
    @(negedge clock);
    while (!in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL issue_timeout: got in_ready 0 for rd %0d, expected 1", rd);
    end else begin
      push_exp(rd, wr, u1, u2, e1, e2);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_wb(input rv_reg_t r, input logic [31:0] v);
    wb_control.enable = 1'b1;
    wb_control.which_register = r;
    wb_control.value = v;
  endtask

  task automatic writeback(input rv_reg_t r, input logic [31:0] v);
    drive_wb(r, v);
    @(posedge clock); #1;
    wb_control = '0;
  endtask

  task automatic expect_ready(input string name, input logic exp);
    @(negedge clock);
    check_output(name, 32'(in_ready), 32'(exp));
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    in_rs1 = 5'd7;
    @(negedge clock);
    check_output("reset_in_ready", 32'(in_ready), 0);
    check_output("reset_out_valid", 32'(out_valid), 0);
    check_output("reset_rf_rs1", 32'(rf_rs1), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Independent stream, one accept per edge.
    issue(0, 1, 0, 0, 1, 1, 0, 0, w); check_output("t1_accept_x1", w, 0);
    issue(0, 1, 0, 0, 2, 1, 0, 0, w); check_output("t1_accept_x2", w, 0);
    issue(0, 1, 0, 0, 3, 1, 0, 0, w); check_output("t1_accept_x3", w, 0);
    @(negedge clock);
    check_output("t1_valid_last", 32'(out_valid), 1);
    @(negedge clock);
    check_output("t1_valid_drop", 32'(out_valid), 0);
    @(posedge clock); #1;
    writeback(1, 32'h11);
    writeback(2, 32'h22);
    writeback(3, 32'h33);

    // RAW stall released the cycle after the producer writes back.
    issue(0, 1, 0, 0, 5, 1, 0, 0, w);
    offer(5, 1, 0, 0, 10, 1);
    expect_ready("t2_stall_a", 0);
    expect_ready("t2_stall_b", 0);
    drive_wb(5, 32'h1234);
    expect_ready("t2_stall_wb_cycle", 0);
    wb_control = '0;
    issue(5, 1, 0, 0, 10, 1, 32'h1234, 0, w);
    check_output("t2_dep_latency", w, 0);
    writeback(10, 32'hA);

    // New write, writeback and kill all hitting x7 on one edge.
    issue(0, 0, 0, 0, 7, 1, 0, 0, w);
    drive_wb(7, 32'h77);
    kill_valid = 1'b1;
    kill_rd = 5'd7;
    issue(0, 0, 0, 0, 7, 1, 0, 0, w);
    check_output("t3_same_cycle_accept", w, 0);
    wb_control = '0;
    kill_valid = 1'b0;
    issue(7, 1, 0, 0, 11, 0, 32'h77, 0, w);
    check_output("t3_x7_clear", w, 0);

    // In-flight limit blocks writes only.
    for (int r = 1; r <= 4; r++) issue(0, 0, 0, 0, rv_reg_t'(r), 1, 0, 0, w);
    offer(0, 0, 0, 0, 11, 1);
    expect_ready("t4_fifth_write", 0);
    issue(9, 1, 0, 0, 0, 0, 0, 0, w);
    check_output("t4_read_x9", w, 0);
    issue(0, 0, 0, 0, 0, 1, 0, 0, w);
    check_output("t4_write_x0", w, 0);
    for (int r = 1; r <= 4; r++) writeback(rv_reg_t'(r), 32'h100 + r);
    issue(0, 0, 0, 0, 11, 1, 0, 0, w);
    check_output("t4_after_wb", w, 0);
    writeback(11, 32'hB);

    // Per-register counter saturation.
    for (int k = 0; k < 3; k++) issue(0, 0, 0, 0, 6, 1, 0, 0, w);
    offer(0, 0, 0, 0, 6, 1);
    expect_ready("t5_saturated", 0);
    in_valid = 1'b0;
    writeback(6, 32'h61);
    writeback(6, 32'h62);
    writeback(6, 32'h63);
    issue(6, 1, 0, 0, 0, 0, 32'h63, 0, w);
    check_output("t5_read_x6", w, 0);

    // Backpressure holds the read address and the output.
    issue(0, 0, 0, 0, 8, 1, 0, 0, w);
    writeback(8, 32'h88);
    out_ready = 1'b0;
    issue(8, 1, 0, 0, 0, 0, 32'h88, 0, w);
    offer(20, 1, 0, 0, 13, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_output("t6_rf_rs1_held", 32'(rf_rs1), 8);
      check_output("t6_out_valid_held", 32'(out_valid), 1);
      check_output("t6_in_ready_low", 32'(in_ready), 0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;

    // Reset mid-operation, then a stale writeback in the first cycle after.
    out_ready = 1'b0;
    issue(0, 0, 0, 0, 3, 1, 0, 0, w);
    @(negedge clock);
    check_output("t7_pre_valid", 32'(out_valid), 1);
    @(posedge clock); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    drive_wb(3, 32'h333);
    offer(3, 1, 0, 0, 0, 0);
    @(negedge clock);
    check_output("t7_valid_cleared", 32'(out_valid), 0);
    check_output("t7_ready_x3", 32'(in_ready), 1);
    if (in_ready) push_exp(0, 0, 1, 0, 32'h103, 0);
    @(posedge clock); #1;
    wb_control = '0;
    in_valid = 1'b0;
    for (int r = 1; r <= 4; r++) issue(0, 0, 0, 0, rv_reg_t'(r), 1, 0, 0, w);
    offer(0, 0, 0, 0, 11, 1);
    expect_ready("t7_inflight_limit", 0);
    in_valid = 1'b0;

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    check_output("drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
